// File: rtl/run_checker_pkg.sv
// Shared definitions for the program-test run controller / result checker.
// Holds the controller state encoding and a width helper for index ports.
package run_checker_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_SCAN_REQ = 3'd2,
      ST_SCAN_CMP = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   // Bits needed to index n entries, never less than one.
   function automatic int clog2_min1(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/run_checker.sv
// Releases the CPU on start, detects branch-to-self halt, then reads back and
// compares data-memory words to produce a pass / fail / timeout verdict.
module run_checker
   import run_checker_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_CHECKS  = 4,
   parameter int HALT_STABLE = 4,
   parameter int MAX_CYCLES  = 500,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            pc,
   input  logic [NUM_CHECKS*ADDR_WIDTH-1:0] chk_addr,
   input  logic [NUM_CHECKS*DATA_WIDTH-1:0] chk_data,
   input  logic [DATA_WIDTH-1:0]            dmem_rdata,
   output logic                             cpu_stall,
   output logic                             dmem_rd,
   output logic [ADDR_WIDTH-1:0]            dmem_addr,
   output logic [CNT_WIDTH-1:0]             cycle_count,
   output logic                             done,
   output logic                             pass,
   output logic                             timeout,
   output logic [clog2_min1(NUM_CHECKS)-1:0] fail_index
);

   localparam int IW = clog2_min1(NUM_CHECKS);
   localparam int SW = clog2_min1(HALT_STABLE);

   // One more equal PC on top of this count completes the halt window.
   localparam logic [SW-1:0]        STABLE_LAST = SW'(HALT_STABLE - 2);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST    = CNT_WIDTH'(MAX_CYCLES - 1);
   localparam logic [IW-1:0]        IDX_LAST    = IW'(NUM_CHECKS - 1);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   pc_prev;
   logic [SW-1:0]           stable_cnt;
   logic [IW-1:0]           idx;
   logic [IW-1:0]           idx_next;
   logic                    pc_same;
   logic                    halt;
   logic                    cmp_ok;

   logic [ADDR_WIDTH-1:0]   addr_tab [NUM_CHECKS];
   logic [DATA_WIDTH-1:0]   data_tab [NUM_CHECKS];

   for (genvar g = 0; g < NUM_CHECKS; g++) begin : g_unpack
      assign addr_tab[g] = chk_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_tab[g] = chk_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign pc_same  = (pc == pc_prev);
   assign halt     = pc_same && (stable_cnt == STABLE_LAST);
   assign idx_next = idx + IW'(1);
   assign cmp_ok   = (dmem_rdata == data_tab[idx]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         pc_prev     <= '0;
         stable_cnt  <= '0;
         idx         <= '0;
         cpu_stall   <= 1'b1;
         dmem_rd     <= 1'b0;
         dmem_addr   <= '0;
         cycle_count <= '0;
         done        <= 1'b0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
         fail_index  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               // pc_prev is captured here so a PC held while stalled already
               // counts toward the halt window on the first RUN cycle.
               if (start) begin
                  state       <= ST_RUN;
                  pc_prev     <= pc;
                  stable_cnt  <= '0;
                  idx         <= '0;
                  cpu_stall   <= 1'b0;
                  cycle_count <= '0;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  timeout     <= 1'b0;
                  fail_index  <= '0;
               end
            end

            ST_RUN: begin
               cycle_count <= cycle_count + CNT_WIDTH'(1);
               pc_prev     <= pc;
               stable_cnt  <= pc_same ? stable_cnt + SW'(1) : '0;
               if (halt) begin
                  state     <= ST_SCAN_REQ;
                  cpu_stall <= 1'b1;
                  idx       <= '0;
                  dmem_rd   <= 1'b1;
                  dmem_addr <= addr_tab[0];
               end else if (cycle_count == CNT_LAST) begin
                  state     <= ST_DONE;
                  cpu_stall <= 1'b1;
                  done      <= 1'b1;
                  timeout   <= 1'b1;
                  pass      <= 1'b0;
               end
            end

            ST_SCAN_REQ: begin
               dmem_rd <= 1'b0;
               state   <= ST_SCAN_CMP;
            end

            ST_SCAN_CMP: begin
               if (!cmp_ok) begin
                  state      <= ST_DONE;
                  done       <= 1'b1;
                  pass       <= 1'b0;
                  fail_index <= idx;
               end else if (idx == IDX_LAST) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  pass  <= 1'b1;
               end else begin
                  idx       <= idx_next;
                  dmem_rd   <= 1'b1;
                  dmem_addr <= addr_tab[idx_next];
                  state     <= ST_SCAN_REQ;
               end
            end

            default: begin
               state     <= ST_IDLE;
               cpu_stall <= 1'b1;
               dmem_rd   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_checker.sv
// Self-checking bench for run_checker: directed vector table, a reset-in-scan
// sequence, and randomized PC traces checked against a window-based model.
module tb_run_checker;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NC = 2;
   localparam int HS = 4;
   localparam int MC = 20;
   localparam int CW = 16;
   localparam int TL = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [AW-1:0]   pc;
   logic [NC*AW-1:0] chk_addr;
   logic [NC*DW-1:0] chk_data;
   logic [DW-1:0]   dmem_rdata;
   logic            cpu_stall;
   logic            dmem_rd;
   logic [AW-1:0]   dmem_addr;
   logic [CW-1:0]   cycle_count;
   logic            done;
   logic            pass;
   logic            timeout;
   logic [0:0]      fail_index;

   always #5 clk = ~clk;

   run_checker #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CHECKS(NC),
      .HALT_STABLE(HS), .MAX_CYCLES(MC), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .pc(pc),
      .chk_addr(chk_addr), .chk_data(chk_data), .dmem_rdata(dmem_rdata),
      .cpu_stall(cpu_stall), .dmem_rd(dmem_rd), .dmem_addr(dmem_addr),
      .cycle_count(cycle_count), .done(done), .pass(pass),
      .timeout(timeout), .fail_index(fail_index)
   );

   // data memory check port, 1-cycle read latency
   logic [DW-1:0] mem [64];
   always @(posedge clk) if (dmem_rd) dmem_rdata <= mem[dmem_addr[7:2]];

   int vectors = 0;
   int miscompares = 0;
   logic [AW-1:0] trace [TL];
   logic [AW-1:0] caddr [NC];
   logic [DW-1:0] cdata [NC];

   typedef struct {
      int            hold;
      logic [DW-1:0] m0;
      logic [DW-1:0] m1;
      int            pulse;
      logic          ep;
      logic          eto;
      int            ecc;
      int            efi;
      int            erds;
   } vec_t;

   vec_t vt [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_checks();
      for (int i = 0; i < NC; i++) begin
         chk_addr[i*AW +: AW] = caddr[i];
         chk_data[i*DW +: DW] = cdata[i];
      end
   endtask

   task automatic fill_hold(input int hold);
      for (int k = 0; k < TL; k++) trace[k] = AW'((k < hold) ? 4*k : 4*hold);
   endtask

   // Halt = first RUN cycle k whose PC equals the previous HS-1 samples
   // (sample 0 is the PC present at start); scan stops at first mismatch.
   task automatic model(output logic ep, output logic eto, output int ecc,
                        output int efi, output int erds);
      int halt_k;
      halt_k = -1;
      ep = 1'b0; eto = 1'b0; efi = 0; erds = 0;
      for (int k = HS-1; k <= MC && halt_k < 0; k++) begin
         bit same;
         same = 1'b1;
         for (int j = 1; j < HS; j++) if (trace[k-j] != trace[k]) same = 1'b0;
         if (same) halt_k = k;
      end
      if (halt_k < 0) begin
         eto = 1'b1;
         ecc = MC;
      end else begin
         ecc = halt_k;
         ep  = 1'b1;
         for (int i = 0; i < NC && ep; i++) begin
            erds++;
            if (mem[caddr[i][7:2]] != cdata[i]) begin
               ep  = 1'b0;
               efi = i;
            end
         end
      end
   endtask

   task automatic do_run(input int pulse_at, output int rds, output bit ok);
      rds = 0;
      ok  = 1'b0;
      pc = trace[0];
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_cc_clear", cycle_count, 0);
      check("start_done_clear", done, 0);
      check("start_unstall", cpu_stall, 0);
      for (int k = 1; k < 200; k++) begin
         pc = trace[(k < TL) ? k : TL-1];
         start = (k == pulse_at);
         step();
         start = 1'b0;
         if (k == pulse_at) check("start_ignored_cc", cycle_count, k);
         if (dmem_rd) rds++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL no_done: got done=0 after 200 cycles expected done=1");
      end
   endtask

   task automatic verdict(input string tag, input logic ep, input logic eto,
                          input int ecc, input int efi, input int erds, input int rds);
      check({tag, "_done"}, done, 1);
      check({tag, "_pass"}, pass, ep);
      check({tag, "_timeout"}, timeout, eto);
      check({tag, "_cycles"}, cycle_count, ecc);
      check({tag, "_rd_pulses"}, rds, erds);
      check({tag, "_stall"}, cpu_stall, 1);
      if (!ep && !eto) check({tag, "_fail_index"}, fail_index, efi);
      step();
      check({tag, "_done_held"}, done, 1);
      check({tag, "_pass_held"}, pass, ep);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  rds;
      bit  ok;
      logic ep, eto;
      int  ecc, efi, erds, k, stick;

      vt[0] = '{hold:3,    m0:5, m1:9, pulse:2, ep:1, eto:0, ecc:6,  efi:0, erds:2};
      vt[1] = '{hold:3,    m0:5, m1:8, pulse:0, ep:0, eto:0, ecc:6,  efi:1, erds:2};
      vt[2] = '{hold:1000, m0:5, m1:9, pulse:5, ep:0, eto:1, ecc:20, efi:0, erds:0};
      vt[3] = '{hold:17,   m0:5, m1:9, pulse:0, ep:1, eto:0, ecc:20, efi:0, erds:2};
      vt[4] = '{hold:18,   m0:5, m1:9, pulse:0, ep:0, eto:1, ecc:20, efi:0, erds:0};
      vt[5] = '{hold:0,    m0:7, m1:9, pulse:0, ep:0, eto:0, ecc:3,  efi:0, erds:1};
      vt[6] = '{hold:0,    m0:5, m1:9, pulse:0, ep:1, eto:0, ecc:3,  efi:0, erds:2};

      for (int i = 0; i < 64; i++) mem[i] = '0;
      caddr[0] = 32'h10; caddr[1] = 32'h14;
      cdata[0] = 32'd5;  cdata[1] = 32'd9;
      load_checks();
      reset = 1'b1; start = 1'b0; pc = '0;
      step();
      step();
      check("rst_cpu_stall", cpu_stall, 1);
      check("rst_dmem_rd", dmem_rd, 0);
      check("rst_dmem_addr", dmem_addr, 0);
      check("rst_cycle_count", cycle_count, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_timeout", timeout, 0);
      check("rst_fail_index", fail_index, 0);
      reset = 1'b0;
      step();
      check("idle_stall", cpu_stall, 1);
      check("idle_done", done, 0);

      for (int v = 0; v < 7; v++) begin
         fill_hold(vt[v].hold);
         mem[4] = vt[v].m0;
         mem[5] = vt[v].m1;
         do_run(vt[v].pulse, rds, ok);
         if (ok) verdict($sformatf("vec%0d", v), vt[v].ep, vt[v].eto,
                         vt[v].ecc, vt[v].efi, vt[v].erds, rds);
      end

      // reset asserted while the first comparison is in progress
      fill_hold(3);
      mem[4] = 5; mem[5] = 9;
      pc = trace[0]; start = 1'b1;
      step();
      start = 1'b0;
      k = 1;
      while (!dmem_rd && k < 50) begin
         pc = trace[k];
         step();
         k++;
      end
      if (!dmem_rd) begin
         vectors++;
         miscompares++;
         $display("FAIL scan_rd_wait: got dmem_rd=0 after 50 cycles expected 1");
      end
      step();
      check("scan_cmp_rd_low", dmem_rd, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midscan_rst_stall", cpu_stall, 1);
      check("midscan_rst_rd", dmem_rd, 0);
      check("midscan_rst_addr", dmem_addr, 0);
      check("midscan_rst_cycles", cycle_count, 0);
      check("midscan_rst_done", done, 0);
      check("midscan_rst_pass", pass, 0);
      check("midscan_rst_timeout", timeout, 0);
      step();
      check("midscan_idle_done", done, 0);
      check("midscan_idle_rd", dmem_rd, 0);

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < NC; i++) begin
            caddr[i] = AW'($urandom_range(0, 63) << 2);
            cdata[i] = $urandom;
         end
         for (int i = 0; i < NC; i++)
            mem[caddr[i][7:2]] = ($urandom_range(0, 3) != 0) ? cdata[i]
                                 : cdata[i] ^ (32'd1 << $urandom_range(0, 31));
         load_checks();
         stick = $urandom_range(0, 3);
         trace[0] = AW'($urandom_range(0, 3) * 4);
         for (int t = 1; t < TL; t++)
            trace[t] = ($urandom_range(0, 3) < stick) ? trace[t-1]
                       : AW'($urandom_range(0, 7) * 4);
         model(ep, eto, ecc, efi, erds);
         do_run(0, rds, ok);
         if (ok) verdict($sformatf("rnd%0d", r), ep, eto, ecc, efi, erds, rds);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
